// File: rtl/memory_arbiter_if.sv
// Bus bundle between the Hack CPU, the screen-scanout DMA and the Memory block.
// slave  : arbiter side
// master : requester / memory-model side
interface memory_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        cpu_err;
  logic        dma_req;
  logic [12:0] dma_addr;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [15:0] dma_rdata;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [14:0] mem_address;
  logic [15:0] mem_out;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr, mem_out,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
           dma_gnt, dma_rvalid, dma_rdata, mem_in, mem_load, mem_address
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr, mem_out,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
           dma_gnt, dma_rvalid, dma_rdata, mem_in, mem_load, mem_address
  );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port memory arbiter: CPU has priority, screen DMA gets a forced
// grant after STARVE_LIMIT consecutive denied cycles. One access per cycle,
// reads return one cycle later on the owner's rvalid/rdata.
// Optional feature macro: MEM_ARB_WRITE_PROTECT_EN (blocks CPU writes to
// addresses >= 0x6000 and pulses cpu_err instead).
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic              CLK,
  input logic              RESET_N,
  memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CPU_RD, CPU_WR, DMA_RD} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        cpu_err_q;
  logic [15:0] cpu_rdata_q, dma_rdata_q;
  logic        dma_win, cpu_gnt, dma_gnt, wp_hit;

`ifdef MEM_ARB_WRITE_PROTECT_EN
  assign wp_hit = (bus.cpu_addr >= 15'h6000);
`else
  assign wp_hit = 1'b0;
`endif

  // Grant decision: DMA only wins when CPU is idle or DMA has starved long enough
  always_comb begin
    dma_win = bus.dma_req && (!bus.cpu_req || (starve_q == LIMIT));
    dma_gnt = dma_win;
    cpu_gnt = bus.cpu_req && !dma_win;
  end

  // Memory pin mux; load is suppressed during reset and for protected writes
  always_comb begin
    bus.mem_address = 15'h0000;
    bus.mem_in      = 16'h0000;
    bus.mem_load    = 1'b0;
    if (cpu_gnt) begin
      bus.mem_address = bus.cpu_addr;
      bus.mem_in      = bus.cpu_wdata;
      bus.mem_load    = bus.cpu_we && !wp_hit && RESET_N;
    end else if (dma_gnt) begin
      bus.mem_address = {2'b10, bus.dma_addr};
    end
  end

  // Next last-grant state and starvation counter
  always_comb begin
    state_d = IDLE;
    if (cpu_gnt)      state_d = bus.cpu_we ? CPU_WR : CPU_RD;
    else if (dma_gnt) state_d = DMA_RD;
    starve_d = 4'd0;
    if (bus.dma_req && !dma_gnt)
      starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
  end

  // Registered state, read-data capture and error pulse
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      cpu_rdata_q <= 16'h0000;
      dma_rdata_q <= 16'h0000;
      cpu_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      cpu_err_q <= cpu_gnt && bus.cpu_we && wp_hit;
      if (state_d == CPU_RD) cpu_rdata_q <= bus.mem_out;
      if (state_d == DMA_RD) dma_rdata_q <= bus.mem_out;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_rvalid = (state_q == CPU_RD);
  assign bus.dma_rvalid = (state_q == DMA_RD);
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.cpu_err    = cpu_err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: behavioural Hack memory, directed scenarios
// and a randomized phase checked against a transaction-level model.
module tb_memory_arbiter;
  localparam int LIMIT = 4;
`ifdef MEM_ARB_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  memory_arbiter_if bus();
  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

  // Memory block: combinational read, write on rising edge
  logic [15:0] mem [0:32767];
  assign bus.mem_out = mem[bus.mem_address];
  always @(posedge CLK) if (bus.mem_load) mem[bus.mem_address] <= bus.mem_in;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [15:0] ref_mem [0:32767];
  int          m_starve;
  logic        x_cpu_rv, x_dma_rv, x_err;
  logic [15:0] x_cpu_rd, x_dma_rd;
  logic        m_cg, m_dg;
  logic        obs_cg, obs_dg, obs_load;
  logic [14:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    x_cpu_rv = 0; x_dma_rv = 0; x_err = 0;
    x_cpu_rd = 0; x_dma_rd = 0;
  endtask

  // One clock cycle: called just after a falling edge
  task automatic step(input logic cr, input logic cw, input logic [14:0] ca,
                      input logic [15:0] cd, input logic dr, input logic [12:0] da);
    logic [14:0] e_addr;
    logic [15:0] e_in;
    logic        e_load, blocked;
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_addr = da;
    #1;
    m_dg = dr && (!cr || m_starve == LIMIT);
    m_cg = cr && !m_dg;
    blocked = WP && (ca >= 15'h6000);
    e_addr = m_cg ? ca : (m_dg ? 15'h4000 + 15'(da) : 15'h0);
    e_in   = m_cg ? cd : 16'h0;
    e_load = m_cg && cw && !blocked;
    obs_cg = bus.cpu_gnt; obs_dg = bus.dma_gnt;
    obs_load = bus.mem_load; obs_addr = bus.mem_address;
    chk("cpu_gnt", bus.cpu_gnt, m_cg);
    chk("dma_gnt", bus.dma_gnt, m_dg);
    chk("mem_address", bus.mem_address, e_addr);
    chk("mem_in", bus.mem_in, e_in);
    chk("mem_load", bus.mem_load, e_load);
    // effects of the coming rising edge
    if (dr && !m_dg) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
    else             m_starve = 0;
    x_cpu_rv = m_cg && !cw;
    if (x_cpu_rv) x_cpu_rd = ref_mem[ca];
    x_dma_rv = m_dg;
    if (x_dma_rv) x_dma_rd = ref_mem[15'h4000 + 15'(da)];
    x_err = m_cg && cw && blocked;
    if (e_load) ref_mem[ca] = cd;
    @(negedge CLK);
    chk("cpu_rvalid", bus.cpu_rvalid, x_cpu_rv);
    chk("cpu_rdata", bus.cpu_rdata, x_cpu_rd);
    chk("dma_rvalid", bus.dma_rvalid, x_dma_rv);
    chk("dma_rdata", bus.dma_rdata, x_dma_rd);
    chk("cpu_err", bus.cpu_err, x_err);
  endtask

  function automatic logic [14:0] rnd_addr();
    case ($urandom_range(0, 3))
      0:       return 15'($urandom_range(0, 7));
      1:       return 15'(16'h4000 + $urandom_range(0, 7));
      2:       return 15'h6000;
      default: return 15'($urandom_range(16'h6000, 16'h7FFF));
    endcase
  endfunction

  initial begin
    logic        cr, cw, dr;
    logic [14:0] ca;
    logic [15:0] cd;
    logic [12:0] da;
    for (int i = 0; i < 32768; i++) begin mem[i] = 16'h0; ref_mem[i] = 16'h0; end
    model_reset();

    // Reset state: registered outputs zero, mem_load held low despite a write request
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 15'h0010; bus.cpu_wdata = 16'h5555;
    bus.dma_req = 0; bus.dma_addr = 0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_mem_load", bus.mem_load, 1'b0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 1'b0);
    chk("rst_cpu_err", bus.cpu_err, 1'b0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 16'h0);
    chk("rst_dma_rdata", bus.dma_rdata, 16'h0);
    bus.cpu_req = 0; bus.cpu_we = 0;
    @(negedge CLK);
    RESET_N = 1;

    // CPU write then read of address 0
    step(1, 1, 15'h0000, 16'hAAAA, 0, 0);
    chk("wr_gnt", obs_cg, 1'b1);
    step(1, 0, 15'h0000, 16'h0000, 0, 0);
    chk("rd_gnt", obs_cg, 1'b1);
    chk("rd_rvalid", bus.cpu_rvalid, 1'b1);
    chk("rd_rdata", bus.cpu_rdata, 16'hAAAA);

    // DMA scanout read of a preloaded screen word
    mem[15'h4005] = 16'h1234; ref_mem[15'h4005] = 16'h1234;
    step(0, 0, 0, 0, 1, 13'h0005);
    chk("dma_addr", obs_addr, 15'h4005);
    chk("dma_rvalid", bus.dma_rvalid, 1'b1);
    chk("dma_rdata", bus.dma_rdata, 16'h1234);
    step(0, 0, 0, 0, 0, 0);
    chk("rdata_hold", bus.dma_rdata, 16'h1234);

    // Both requesting continuously: CPU x4 then DMA, repeating
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 15'h0000, 0, 1, 13'h0005);
      chk("starve_pattern", obs_dg, (i % 5) == 4);
      chk("one_hot_gnt", obs_cg & obs_dg, 1'b0);
    end
    step(0, 0, 0, 0, 0, 0);

    // Write to keyboard address: protection behaviour depends on the build
    step(1, 1, 15'h6000, 16'hEEEE, 0, 0);
    chk("wp_mem_load", obs_load, !WP);
    chk("wp_cpu_err", bus.cpu_err, WP);
    step(0, 0, 0, 0, 0, 0);
    chk("wp_err_one_cycle", bus.cpu_err, 1'b0);

    // Reset pulse while a read is in flight
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h0000;
    bus.dma_req = 0;
    #3 RESET_N = 0;
    @(negedge CLK);
    chk("mid_rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk("mid_rst_cpu_rdata", bus.cpu_rdata, 16'h0);
    chk("mid_rst_dma_rdata", bus.dma_rdata, 16'h0);
    chk("mid_rst_err", bus.cpu_err, 1'b0);
    bus.cpu_we = 1; bus.cpu_wdata = 16'hDEAD;
    #1 chk("mid_rst_load", bus.mem_load, 1'b0);
    bus.cpu_req = 0; bus.cpu_we = 0;
    #1;
    chk("mid_rst_addr", bus.mem_address, 15'h0);
    chk("mid_rst_gnt", {bus.cpu_gnt, bus.dma_gnt}, 2'b00);
    @(negedge CLK);
    RESET_N = 1;
    model_reset();
    step(1, 0, 15'h0000, 0, 0, 0);
    chk("post_rst_rdata", bus.cpu_rdata, 16'hAAAA);

    // Randomized traffic; denied requesters hold their request
    cr = 0; cw = 0; ca = 0; cd = 0; dr = 0; da = 0;
    m_cg = 0; m_dg = 0;
    for (int n = 0; n < 400; n++) begin
      if (!(cr && !m_cg)) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = $urandom_range(0, 1);
        ca = rnd_addr();
        cd = 16'($urandom);
      end
      if (!(dr && !m_dg)) begin
        dr = $urandom_range(0, 1);
        da = 13'($urandom_range(0, 7));
      end
      step(cr, cw, ca, cd, dr, da);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive denied DMA-request cycles after which DMA is forced a grant; legal range 1..15.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 cpu_req  input  1  CPU access request, sampled every cycle.
REQ-005 cpu_we  input  1  CPU write (1) / read (0), qualified by cpu_req.
REQ-006 cpu_addr  input  15  CPU word address, full Hack map: RAM 0x0000-0x3FFF, screen 0x4000-0x5FFF, keyboard 0x6000.
REQ-007 cpu_wdata  input  16  CPU write data.
REQ-008 cpu_gnt  output  1  combinational, CPU access performed this cycle.
REQ-009 cpu_rvalid / cpu_rdata  output  1 / 16  registered read return for the CPU.
REQ-010 cpu_err  output  1  registered one-cycle pulse, CPU write rejected by write protection.
REQ-011 dma_req  input  1  screen-scanout read request.
REQ-012 dma_addr  input  13  screen word offset 0x0000-0x1FFF.
REQ-013 dma_gnt  output  1  combinational, DMA read performed this cycle.
REQ-014 dma_rvalid / dma_rdata  output  1 / 16  registered read return for the DMA port.
REQ-015 mem_in / mem_load / mem_address  output  16 / 1 / 15  drive the Memory block's in, load and address pins.
REQ-016 mem_out  input  16  Memory block read data, combinational from mem_address.

Function
REQ-017 At most one of cpu_gnt or dma_gnt SHALL be high in any cycle; a grant is issued whenever any request is high.
REQ-018 Priority: CPU wins, except when starve_cnt == STARVE_LIMIT and dma_req=1, in which case DMA wins.
REQ-019 starve_cnt (4-bit): increments, saturating at STARVE_LIMIT, on each cycle with dma_req=1 and dma_gnt=0; clears on dma_gnt=1 or dma_req=0.
REQ-020 CPU grant: mem_address=cpu_addr, mem_in=cpu_wdata, mem_load=cpu_we (subject to REQ-030).
REQ-021 DMA grant: mem_address=0x4000+dma_addr, mem_load=0, mem_in=0.
REQ-022 No grant: mem_address=0, mem_in=0, mem_load=0.
REQ-023 Read latency is 1 cycle: a granted read captures mem_out at the rising edge; the owner's rvalid is high and rdata valid for exactly the following cycle.
REQ-024 A CPU write returns no rvalid; cpu_rvalid=0 the cycle after it.
REQ-025 rdata holds its last value while its rvalid is low.
REQ-026 Last-grant state register: IDLE, CPU_RD, CPU_WR, DMA_RD. It loads from the current cycle's grant and selects which rvalid fires next cycle.
REQ-027 Back-to-back grants are supported at 1 access/cycle with no bubble, including a CPU-to-DMA switch.
REQ-028 A requester that is denied SHALL keep req and its address/data stable until granted; the arbiter does not queue requests.

Reset
REQ-029 While RESET_N=0: state=IDLE, starve_cnt=0, cpu_rvalid=dma_rvalid=cpu_err=0, cpu_rdata=dma_rdata=0, and mem_load forced 0 regardless of requests. A read granted in the cycle reset asserts returns no rvalid.

Configuration
REQ-030 With MEM_ARB_WRITE_PROTECT_EN defined, a CPU write to any address >= 0x6000 is granted, but forces mem_load=0 and pulses cpu_err the next cycle. Without the macro, mem_load=cpu_we for all addresses and cpu_err is tied to 0.

Verification
REQ-031 CPU write 0x0000<-0xAAAA, then CPU read 0x0000 -> cpu_gnt=1 both cycles; cpu_rvalid=1 with cpu_rdata=0xAAAA one cycle after the read.
REQ-032 Preload 0x4005=0x1234; dma_req=1 with dma_addr=0x0005, cpu_req=0 -> mem_address=0x4005; dma_rvalid=1 with dma_rdata=0x1234 next cycle.
REQ-033 cpu_req and dma_req held high continuously with STARVE_LIMIT=4 -> grant pattern CPU,CPU,CPU,CPU,DMA repeating; never both grants high.
REQ-034 MEM_ARB_WRITE_PROTECT_EN defined; CPU write 0x6000<-0xEEEE -> mem_load=0, cpu_err=1 for one cycle; without the macro -> mem_load=1 and cpu_err=0.
REQ-035 CPU read granted, RESET_N pulsed low before the next edge -> no cpu_rvalid; all outputs at reset values; next request served normally.
